fibonacci_checker: RTL

- Receive-side counterpart to the fibonacci generator. It samples a WIDTH-bit bus carrying a Fibonacci stream, for example from io_in pads or looped back from another project.
- It self-synchronises on two consecutive samples and predicts each following term modulo 2^WIDTH.
- It counts matches and mismatches and reports lock status, so the silicon generator can be checked through the logic analyzer.

---
 rtl/fibonacci_checker_if.sv | 35 +++
 rtl/fibonacci_checker.sv | 122 ++++++++++++
 2 files changed

// File: rtl/fibonacci_checker_if.sv
// rtl/fibonacci_checker_if.sv - sample bus and status signals of the Fibonacci stream checker
interface fibonacci_checker_if #(
  parameter int WIDTH = 30,
  parameter int CNT_W = 16
);
  logic             sample_valid;
  logic [WIDTH-1:0] sample;
  logic             locked;
  logic             error_pulse;
  logic [CNT_W-1:0] match_count;
  logic [CNT_W-1:0] error_count;
  logic [WIDTH-1:0] expected;

  // Stream source / observer side
  modport master (
    output sample_valid,
    output sample,
    input  locked,
    input  error_pulse,
    input  match_count,
    input  error_count,
    input  expected
  );

  // Checker side
  modport slave (
    input  sample_valid,
    input  sample,
    output locked,
    output error_pulse,
    output match_count,
    output error_count,
    output expected
  );
endinterface

// File: rtl/fibonacci_checker.sv
// rtl/fibonacci_checker.sv - self-synchronising Fibonacci stream checker; FIB_CHECK_IRQ_EN adds sticky irq/irq_clr
module fibonacci_checker #(
  parameter int WIDTH       = 30,
  parameter int CNT_W       = 16,
  parameter int RELOCK_ERRS = 3
) (
  input  logic                clk,
  input  logic                reset,
`ifdef FIB_CHECK_IRQ_EN
  output logic                irq,
  input  logic                irq_clr,
`endif
  fibonacci_checker_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ONE    = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [3:0]       RELOCK_LIMIT = 4'(RELOCK_ERRS);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;

  state_t           state;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] exp_term;
  logic [3:0]       err_run;
  logic [3:0]       err_run_inc;
  logic             hit;
  logic             mismatch;

  // Prediction wraps modulo 2^WIDTH, matching a truncating generator
  assign exp_term    = prev + cur;
  assign err_run_inc = err_run + 4'd1;
  assign hit         = (bus.sample == exp_term);
  assign mismatch    = bus.sample_valid && (state == ST_LOCKED) && !hit;

  // Sync/lock FSM with history, counters and all registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_EMPTY;
      prev            <= '0;
      cur             <= '0;
      err_run         <= '0;
      bus.locked      <= 1'b0;
      bus.error_pulse <= 1'b0;
      bus.match_count <= '0;
      bus.error_count <= '0;
      bus.expected    <= '0;
    end else begin
      bus.error_pulse <= 1'b0;
      if (bus.sample_valid) begin
        unique case (state)
          ST_EMPTY: begin
            cur   <= bus.sample;
            state <= ST_ONE;
          end
          ST_ONE: begin
            prev <= cur;
            cur  <= bus.sample;
            // An all-zero pair is a stuck bus, not a Fibonacci seed
            if (cur != '0 || bus.sample != '0) begin
              state        <= ST_LOCKED;
              bus.locked   <= 1'b1;
              bus.expected <= cur + bus.sample;
            end
          end
          ST_LOCKED: begin
            if (hit) begin
              prev         <= cur;
              cur          <= bus.sample;
              err_run      <= '0;
              bus.expected <= cur + bus.sample;
              if (bus.match_count != CNT_MAX) begin
                bus.match_count <= bus.match_count + 1'b1;
              end
            end else begin
              bus.error_pulse <= 1'b1;
              if (bus.error_count != CNT_MAX) begin
                bus.error_count <= bus.error_count + 1'b1;
              end
              if (err_run_inc < RELOCK_LIMIT) begin
                // Flywheel: keep following our own prediction across a glitch
                err_run      <= err_run_inc;
                prev         <= cur;
                cur          <= exp_term;
                bus.expected <= cur + exp_term;
              end else begin
                // Too many misses in a row: restart sync from this sample
                state        <= ST_ONE;
                prev         <= '0;
                cur          <= bus.sample;
                err_run      <= '0;
                bus.locked   <= 1'b0;
                bus.expected <= '0;
              end
            end
          end
          default: begin
            state <= ST_EMPTY;
          end
        endcase
      end
    end
  end

`ifdef FIB_CHECK_IRQ_EN
  // Sticky error flag; a new error beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      irq <= 1'b0;
    end else if (mismatch) begin
      irq <= 1'b1;
    end else if (irq_clr) begin
      irq <= 1'b0;
    end
  end
`endif

endmodule
